// File: rtl/xalu_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : xalu_arb_if
// Description : Bundle of requester-side handshake, ALU-side and response
//               signals for the xalu_arb round-robin ALU arbiter.
//               slave  : arbiter view (drives ready, ALU inputs, responses)
//               master : requester/ALU environment view
//               Requester i occupies slice [i*W +: W] of each packed field.
// Revision    : 1.0  initial release
// ============================================================================
interface xalu_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int FNS_W  = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*FNS_W-1:0]  req_fns;
  logic [N_REQ*DATA_W-1:0] req_op_a;
  logic [N_REQ*DATA_W-1:0] req_op_b;
  logic [DATA_W-1:0]       alu_op_a;
  logic [DATA_W-1:0]       alu_op_b;
  logic [FNS_W-1:0]        alu_fns;
  logic [DATA_W-1:0]       alu_result;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    idle;

  modport slave (
    input  req_valid, req_fns, req_op_a, req_op_b, alu_result,
    output req_ready, alu_op_a, alu_op_b, alu_fns, rsp_valid, rsp_data, idle
  );

  modport master (
    output req_valid, req_fns, req_op_a, req_op_b, alu_result,
    input  req_ready, alu_op_a, alu_op_b, alu_fns, rsp_valid, rsp_data, idle
  );
endinterface
`default_nettype wire

// File: rtl/xalu_arb.sv
`default_nettype none
// ============================================================================
// Module      : xalu_arb
// Description : Round-robin arbiter sharing one two-cycle xalu among N_REQ
//               requesters. Grants at most one request per cycle, muxes its
//               operands onto the ALU, registers the function code so it
//               lines up with the ALU's operand registers, and returns each
//               result two cycles later with a one-hot response strobe.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus        - xalu_arb_if.slave (requests, ALU, responses, idle)
// Revision    : 1.0  initial release
// ============================================================================
module xalu_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int FNS_W  = 4,
  parameter int BURST  = 4
) (
  input wire        clk,
  input wire        rst,
  xalu_arb_if.slave bus
);

  localparam int          c_id_w      = $clog2(N_REQ);
  localparam int          c_cnt_w     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [31:0] c_burst_max = 32'(BURST - 1);

  logic [c_id_w-1:0]  r_owner;
  logic [c_cnt_w-1:0] r_burst_cnt;
  logic               r_granted_last;
  logic [FNS_W-1:0]   r_fns;
  logic               r_tag1_v, r_tag2_v;
  logic [N_REQ-1:0]   r_tag1_id, r_tag2_id;

  logic               w_hold;
  logic               w_found;
  logic [c_id_w-1:0]  w_grant_id;
  logic [N_REQ-1:0]   w_grant;

  // Owner keeps the grant while its burst budget lasts; otherwise search
  // starts just after the owner and visits the owner itself last.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_hold     = bus.req_valid[r_owner] && r_granted_last &&
                 (32'(r_burst_cnt) < c_burst_max);
    w_found    = w_hold;
    w_grant_id = r_owner;
    if (!w_hold) begin
      for (int k = 1; k <= N_REQ; k++) begin
        v_idx = int'(r_owner) + k;
        if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
        if (!w_found && bus.req_valid[v_idx]) begin
          w_found    = 1'b1;
          w_grant_id = c_id_w'(v_idx);
        end
      end
    end
    w_grant = w_found ? (N_REQ'(1) << w_grant_id) : '0;
  end

  assign bus.req_ready = w_grant;
  assign bus.alu_op_a  = w_found ? bus.req_op_a[w_grant_id*DATA_W +: DATA_W] : '0;
  assign bus.alu_op_b  = w_found ? bus.req_op_b[w_grant_id*DATA_W +: DATA_W] : '0;
  assign bus.alu_fns   = r_fns;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner        <= c_id_w'(N_REQ - 1);
      r_burst_cnt    <= '0;
      r_granted_last <= 1'b0;
      r_fns          <= '0;
      r_tag1_v       <= 1'b0;
      r_tag1_id      <= '0;
      r_tag2_v       <= 1'b0;
      r_tag2_id      <= '0;
    end else begin
      r_tag1_v  <= w_found;
      r_tag1_id <= w_grant;
      r_tag2_v  <= r_tag1_v;
      r_tag2_id <= r_tag1_id;
      if (w_found) begin
        r_fns          <= bus.req_fns[w_grant_id*FNS_W +: FNS_W];
        r_owner        <= w_grant_id;
        r_granted_last <= 1'b1;
        if (w_grant_id == r_owner && r_granted_last) begin
          // Saturate: once the budget is spent the hold rule is off anyway.
          if (32'(r_burst_cnt) < c_burst_max)
            r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
        end else begin
          r_burst_cnt <= '0;
        end
      end else begin
        r_burst_cnt    <= '0;
        r_granted_last <= 1'b0;
      end
    end
  end

  // Masked by rst so nothing in flight leaks out while reset is held.
  assign bus.rsp_valid = (r_tag2_v && !rst) ? r_tag2_id : '0;
  assign bus.rsp_data  = bus.alu_result;
  assign bus.idle      = !(|bus.req_valid) && !r_tag1_v && !r_tag2_v;

endmodule
`default_nettype wire
